// File: rtl/summer_pkg.sv
// Shared helpers for the element summing matrix: latency, slice packing and
// saturation limits.
package summer_pkg;

   localparam int unsigned CNT_W = 16;

   function automatic int unsigned lat(input int unsigned n);
      return 32'($clog2(n)) + 32'd2;
   endfunction

   // LSB of slice s of unit (element or qubit) in a flat sample vector
   function automatic int unsigned slice_lsb(input int unsigned unit, input int unsigned s,
                                             input int unsigned tslice, input int unsigned dw);
      return (unit * tslice + s) * dw;
   endfunction

   function automatic longint sat_max(input int unsigned w);
      return (64'sd1 <<< (w - 1)) - 64'sd1;
   endfunction

   function automatic longint sat_min(input int unsigned w);
      return -(64'sd1 <<< (w - 1));
   endfunction

endpackage

// File: rtl/element_summer_if.sv
// Sample/mask bus between the waveform elements, the summer and the monitor registers.
interface element_summer_if #(
   parameter int unsigned nelem  = 4,
   parameter int unsigned tslice = 4,
   parameter int unsigned qbits  = 4,
   parameter int unsigned dw     = 16
);
   logic [nelem*tslice*dw-1:0] xin;
   logic [nelem*tslice*dw-1:0] yin;
   logic [nelem*qbits-1:0]     qsel;
   logic [nelem-1:0]           ein_active;
   logic                       ovf_clr;
   logic [qbits*tslice*dw-1:0] xout;
   logic [qbits*tslice*dw-1:0] yout;
   logic [qbits-1:0]           qactive;
   logic [qbits-1:0]           ovf;
   logic [15:0]                sat_count;

   modport master (
      output xin, yin, qsel, ein_active, ovf_clr,
      input  xout, yout, qactive, ovf, sat_count
   );

   modport slave (
      input  xin, yin, qsel, ein_active, ovf_clr,
      output xout, yout, qactive, ovf, sat_count
   );
endinterface

// File: rtl/sat_add_tree.sv
// One (qubit, slice, I/Q) lane: registered binary adder tree over nelem terms,
// followed by a registered clamp to the dw-bit signed range.
module sat_add_tree
   import summer_pkg::*;
#(
   parameter int unsigned nelem = 4,
   parameter int unsigned dw    = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [nelem-1:0][dw-1:0]   terms,
   output logic [dw-1:0]              sum,
   output logic                       sat
);
   localparam int unsigned LG = $clog2(nelem);
   localparam int unsigned SW = dw + LG;
   localparam logic signed [SW-1:0] MAXV = SW'(sat_max(dw));
   localparam logic signed [SW-1:0] MINV = SW'(sat_min(dw));

   // Level k holds nelem>>k partial sums, each dw+k bits wide, so no wrap is possible
   for (genvar k = 0; k <= LG; k++) begin : lvl
      localparam int unsigned N = nelem >> k;
      localparam int unsigned W = dw + k;
      logic signed [W-1:0] v [N];

      if (k == 0) begin : g_in
         always_comb begin
            for (int i = 0; i < N; i++) v[i] = signed'(terms[i]);
         end
      end else begin : g_add
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < N; i++) v[i] <= '0;
            end else begin
               for (int i = 0; i < N; i++)
                  v[i] <= W'(lvl[k-1].v[2*i]) + W'(lvl[k-1].v[2*i+1]);
            end
         end
      end
   end

   logic signed [SW-1:0] full;
   logic                 hi;
   logic                 lo;

   assign full = lvl[LG].v[0];
   assign hi   = full > MAXV;
   assign lo   = full < MINV;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum <= '0;
         sat <= 1'b0;
      end else begin
         sum <= hi ? dw'(MAXV) : (lo ? dw'(MINV) : dw'(full));
         sat <= hi | lo;
      end
   end
endmodule

// File: rtl/element_summer.sv
// Summing matrix: masks element samples per qubit, sums them through pipelined
// saturating adder trees and tracks sticky overflow and saturation counts.
module element_summer
   import summer_pkg::*;
#(
   parameter int unsigned nelem  = 4,
   parameter int unsigned tslice = 4,
   parameter int unsigned qbits  = 4,
   parameter int unsigned dw     = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   element_summer_if.slave bus
);
   localparam int unsigned NLAT = lat(nelem);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [nelem-1:0][tslice-1:0][dw-1:0]            xin_v;
   logic [nelem-1:0][tslice-1:0][dw-1:0]            yin_v;
   logic [qbits-1:0][nelem-1:0]                     mask_c;
   logic [qbits-1:0][tslice-1:0][nelem-1:0][dw-1:0] term_x;
   logic [qbits-1:0][tslice-1:0][nelem-1:0][dw-1:0] term_y;
   logic [qbits-1:0]                                act_pipe [NLAT];
   logic [qbits-1:0][tslice-1:0][dw-1:0]            sum_x;
   logic [qbits-1:0][tslice-1:0][dw-1:0]            sum_y;
   logic [qbits-1:0][tslice-1:0]                    sat_x;
   logic [qbits-1:0][tslice-1:0]                    sat_y;
   logic [qbits-1:0]                                sat_hit;
   logic [qbits-1:0]                                ovf_r;
   logic [CNT_W-1:0]                                cnt;

   assign xin_v = bus.xin;
   assign yin_v = bus.yin;

   always_comb begin
      mask_c = '0;
      for (int q = 0; q < qbits; q++)
         for (int e = 0; e < nelem; e++)
            mask_c[q][e] = bus.qsel[e*qbits+q] & bus.ein_active[e];
   end

   // Stage 0: masked per-qubit terms, re-evaluated every cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         term_x <= '0;
         term_y <= '0;
      end else begin
         for (int q = 0; q < qbits; q++)
            for (int s = 0; s < tslice; s++)
               for (int e = 0; e < nelem; e++) begin
                  term_x[q][s][e] <= mask_c[q][e] ? xin_v[e][s] : '0;
                  term_y[q][s][e] <= mask_c[q][e] ? yin_v[e][s] : '0;
               end
      end
   end

   // qactive travels alongside the data through all NLAT stages
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NLAT; i++) act_pipe[i] <= '0;
      end else begin
         for (int q = 0; q < qbits; q++) act_pipe[0][q] <= |mask_c[q];
         for (int i = 1; i < NLAT; i++) act_pipe[i] <= act_pipe[i-1];
      end
   end

   for (genvar q = 0; q < qbits; q++) begin : g_q
      for (genvar s = 0; s < tslice; s++) begin : g_s
         sat_add_tree #(.nelem(nelem), .dw(dw)) u_x (
            .clk   (clk),
            .rst_n (rst_n),
            .terms (term_x[q][s]),
            .sum   (sum_x[q][s]),
            .sat   (sat_x[q][s])
         );
         sat_add_tree #(.nelem(nelem), .dw(dw)) u_y (
            .clk   (clk),
            .rst_n (rst_n),
            .terms (term_y[q][s]),
            .sum   (sum_y[q][s]),
            .sat   (sat_y[q][s])
         );
      end
   end

   always_comb begin
      sat_hit = '0;
      for (int q = 0; q < qbits; q++)
         for (int s = 0; s < tslice; s++)
            sat_hit[q] = sat_hit[q] | sat_x[q][s] | sat_y[q][s];
   end

   // A clamp arriving in the clear cycle still counts: set wins over clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_r <= '0;
         cnt   <= '0;
      end else if (bus.ovf_clr) begin
         ovf_r <= sat_hit;
         cnt   <= CNT_W'(|sat_hit);
      end else begin
         ovf_r <= ovf_r | sat_hit;
         if ((|sat_hit) && (cnt != CNT_MAX)) cnt <= cnt + CNT_W'(1);
      end
   end

   assign bus.xout      = sum_x;
   assign bus.yout      = sum_y;
   assign bus.qactive   = act_pipe[NLAT-1];
   assign bus.ovf       = ovf_r;
   assign bus.sat_count = cnt;
endmodule

// File: doc/element_summer.md
# element_summer

Summing matrix that sits directly downstream of the waveform elements. It takes the rotated I/Q sample vectors, per-element qubit-select masks and active flags from `nelem` elements. It produces one saturated I/Q sample vector per qubit (DAC channel) each clock, through a fixed-latency pipelined adder tree. Sticky overflow flags and a saturation-event counter support run-time monitoring from the register bus.

## Interface
Parameters:
- `nelem`, 4: number of element inputs; power of two, ≥2.
- `tslice`, 4: samples per clock per channel.
- `qbits`, 4: number of output qubit channels.
- `dw`, 16: sample width, signed two's complement.

Ports:
- `clk`  in  1  sole clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `xin`  in  nelem·tslice·dw  element I samples; element e, slice s at bits `[(e·tslice+s)·dw +: dw]`.
- `yin`  in  nelem·tslice·dw  element Q samples, same packing.
- `qsel`  in  nelem·qbits  element e routes to qubit q when bit `e·qbits+q` is set; multiple bits allowed.
- `ein_active`  in  nelem  element e output valid; when 0, its samples are treated as zero.
- `xout`  out  qbits·tslice·dw  summed I; qubit q, slice s at `[(q·tslice+s)·dw +: dw]`.
- `yout`  out  qbits·tslice·dw  summed Q, same packing.
- `qactive`  out  qbits  at least one active element routed to qubit q, aligned with `xout`/`yout`.
- `ovf`  out  qbits  sticky: saturation occurred on qubit q (I or Q, any slice).
- `ovf_clr`  in  1  single-cycle strobe; clears `ovf` and `sat_count`.
- `sat_count`  out  16  number of cycles with any saturation; holds at 0xFFFF.

## Operation
- Masking, stage 0: for each (q, e), the contribution of element e to qubit q is its I and Q samples when `qsel[e·qbits+q] & ein_active[e]` is set, else 0. The mask is evaluated per cycle, with no hold-over.
- Adder tree: for each (q, s, I/Q), the nelem masked terms are summed by a binary tree of log2(nelem) registered levels.
  - Tree level k carries width dw+k.
  - Full-precision sum width is dw+log2(nelem).
  - No wrap is possible inside the tree.
- Saturation, final stage: the full-precision sum is clamped to [−2^(dw−1), 2^(dw−1)−1] and registered onto `xout`/`yout`.
  - A per-qubit `sat_hit[q]` is the OR over slices and over I/Q of a clamp occurring in that cycle.
- `qactive[q]` is the OR over e of the stage-0 mask, delayed to match the data.
- `ovf[q]`:
  - Set by `sat_hit[q]`.
  - Cleared by `ovf_clr`.
  - When both occur in the same cycle, set wins.
- `sat_count`:
  - Increments by 1 on any cycle with `|sat_hit`, saturating at 0xFFFF.
  - `ovf_clr` loads 0, or 1 if `|sat_hit` in the same cycle.
- Reset:
  - All pipeline registers, `xout`, `yout`, `qactive`, `ovf` and `sat_count` go to 0 immediately on `rst_n` low.
  - After release, outputs reflect post-reset inputs only, i.e. zeros drain for LAT cycles.

## Timing
- LAT = log2(nelem)+2 clocks from inputs to `xout`/`yout`/`qactive`; LAT is 4 for nelem=4.
  - Stage 0 register: masked terms.
  - log2(nelem) tree levels.
  - 1 saturation register.
- `ovf` and `sat_count` update one clock after the corresponding `xout` sample appears, i.e. LAT+1 after input.
- Fully pipelined: a new input vector is accepted every clock. There is no handshake and no stall.
- `ovf_clr` acts on the clock edge where it is sampled high. A saturation that is in flight in the pipeline still sets `ovf` when it arrives.
- `qsel`/`ein_active` are sampled in the same cycle as `xin`/`yin`. The upstream element already aligns them to its data.

## Structure
- Shared package/header `summer_pkg`: `LAT` function of nelem, the slice packing index helpers, and the saturation limit constants derived from dw.
- One sub-module, `sat_add_tree`: a single (q, s) lane with nelem inputs, a registered binary tree, a clamp register and a `sat` flag output. It is instantiated qbits·tslice·2 times.
- The top level holds masking, `qactive` delay, `ovf`/`sat_count` logic, and packing.

## Test plan
- Routing:
  - Stimulus: element 0 drives I=100 on all slices, qsel=0b0001; element 1 drives I=−50, qsel=0b0010; both active.
  - Required: after exactly 4 clocks, qubit 0 I=100, qubit 1 I=−50, qubits 2–3 zero; `qactive`=0b0011.
- Summation:
  - Stimulus: all 4 elements I=1000, Q=−1000, qsel=0b0100.
  - Required: qubit 2 I=4000, Q=−4000; no `ovf`; `sat_count`=0.
- Saturation:
  - Stimulus: 4 elements at I=0x7000, qsel=0b1000, for 3 cycles.
  - Required: qubit 3 I=0x7FFF; `ovf`=0b1000; `sat_count`=3. A further 2 cycles with elements I=−0x7000 give I=−0x8000 and `sat_count`=5.
- Inactive masking:
  - Stimulus: element 2 with qsel=0b0001, I=500, `ein_active`=0.
  - Required: qubit 0 output 0; `qactive[0]`=0.
- Clear collision:
  - Stimulus: `ovf_clr` pulsed in the same cycle a saturation reaches the final stage.
  - Required: `ovf` stays set; `sat_count`=1.
- Reset mid-stream:
  - Stimulus: assert `rst_n` low asynchronously during saturating traffic.
  - Required: all outputs 0 within the same clock period; after release, the first LAT outputs are 0.
